// File: rtl/sram_ctrl_pkg.sv
// Shared types and timing defaults for the single-bit SRAM array access sequencer.
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRECHG,
      WRITE,
      READ,
      RESP
   } state_t;

   localparam int DEF_NUM_CELLS  = 8;
   localparam int DEF_AW         = 3;
   localparam int DEF_PRE_CYCLES = 1;
   localparam int DEF_RD_CYCLES  = 2;

   // Wide enough to hold the longest phase length loaded on state entry.
   function automatic int cnt_width(input int pre_cycles, input int rd_cycles);
      int longest;
      longest = (pre_cycles > rd_cycles) ? pre_cycles : rd_cycles;
      return $clog2(longest) + 1;
   endfunction

endpackage

// File: rtl/sram_onehot_dec.sv
// One-hot cell select: the latched address drives either the word lines or the write bits.
module sram_onehot_dec #(
   parameter int AW        = 3,
   parameter int NUM_CELLS = 8
) (
   input  logic [AW-1:0]        addr,
   input  logic                 en,
   input  logic                 sel_wb,
   output logic [NUM_CELLS-1:0] wl,
   output logic [NUM_CELLS-1:0] wb
);

   logic [NUM_CELLS-1:0] onehot;

   // Addresses at or above NUM_CELLS match no bit, so the select stays all-zero.
   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (en && (addr == AW'(i))) begin
            onehot[i] = 1'b1;
         end
      end
      wl = sel_wb ? '0 : onehot;
      wb = sel_wb ? onehot : '0;
   end

endmodule

// File: rtl/sram_bit_array_ctrl.sv
// Precharge / access / respond sequencer in front of NUM_CELLS single-bit SRAM cells.
// Request and response channels: a transfer happens at a clock edge where valid && ready are both high.
module sram_bit_array_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int NUM_CELLS  = DEF_NUM_CELLS,
   parameter int AW         = DEF_AW,
   parameter int PRE_CYCLES = DEF_PRE_CYCLES,
   parameter int RD_CYCLES  = DEF_RD_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [AW-1:0]        req_addr,
   input  logic                 req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_rdata,
   output logic                 rsp_err,
   output logic                 cell_rst_n,
   output logic [NUM_CELLS-1:0] cell_wl,
   output logic                 cell_blb,
   output logic [NUM_CELLS-1:0] cell_wb,
   output logic                 cell_write_en,
   output logic                 cell_data_in,
   input  logic                 cell_data_out
);

   localparam int            CW     = cnt_width(PRE_CYCLES, RD_CYCLES);
   localparam logic [CW-1:0] PRE_LD = CW'(PRE_CYCLES);
   localparam logic [CW-1:0] RD_LD  = CW'(RD_CYCLES);
   localparam logic [CW-1:0] ONE    = CW'(1);
   localparam logic [AW:0]   LIMIT  = (AW+1)'(NUM_CELLS);

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [AW-1:0] addr_q;
   logic          we_q, wdata_q;
   logic          accept, req_oob, last_cnt;

   assign accept   = req_valid && req_ready;
   assign req_oob  = ({1'b0, req_addr} >= LIMIT);
   assign last_cnt = (cnt == ONE);

   // Out-of-range requests sit one idle-valued cycle in PRECHG, so the error response
   // appears one cycle after accept while no cell control ever moves.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = PRECHG;
               cnt_next   = req_oob ? ONE : PRE_LD;
            end
         end
         PRECHG: begin
            if (!last_cnt) begin
               cnt_next = cnt - ONE;
            end else if (rsp_err) begin
               state_next = RESP;
               cnt_next   = '0;
            end else if (we_q) begin
               state_next = WRITE;
               cnt_next   = ONE;
            end else begin
               state_next = READ;
               cnt_next   = RD_LD;
            end
         end
         WRITE, READ: begin
            if (last_cnt) begin
               state_next = RESP;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt - ONE;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b0;
         rsp_rdata <= 1'b0;
         rsp_err   <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         req_ready <= (state_next == IDLE);
         if (accept) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rsp_err   <= req_oob;
            rsp_rdata <= 1'b0;
         end
         // The read bus is taken raw on the last word-line cycle; Z/X is kept, not masked.
         if ((state == READ) && last_cnt) begin
            rsp_rdata <= cell_data_out;
         end
      end
   end

   assign rsp_valid     = (state == RESP);
   assign cell_rst_n    = ~reset;
   assign cell_blb      = (state != READ);
   assign cell_write_en = (state == WRITE);
   assign cell_data_in  = (state == WRITE) && wdata_q;

   sram_onehot_dec #(
      .AW        (AW),
      .NUM_CELLS (NUM_CELLS)
   ) u_dec (
      .addr   (addr_q),
      .en     ((state == WRITE) || (state == READ)),
      .sel_wb (state == WRITE),
      .wl     (cell_wl),
      .wb     (cell_wb)
   );

endmodule

// File: tb/tb_sram_bit_array_ctrl.sv
// Directed and swept accesses against a transaction-level memory model and a cycle timeline
// derived from the access latencies.
module tb_sram_bit_array_ctrl;

   localparam int NUM_CELLS = 6;
   localparam int AW        = 3;
   localparam int PRE       = 1;
   localparam int RD        = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 req_valid, req_ready, req_we, req_wdata;
   logic [AW-1:0]        req_addr;
   logic                 rsp_valid, rsp_ready, rsp_rdata, rsp_err;
   logic                 cell_rst_n, cell_blb, cell_write_en, cell_data_in, cell_data_out;
   logic [NUM_CELLS-1:0] cell_wl, cell_wb;

   sram_bit_array_ctrl #(
      .NUM_CELLS  (NUM_CELLS),
      .AW         (AW),
      .PRE_CYCLES (PRE),
      .RD_CYCLES  (RD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .cell_rst_n    (cell_rst_n),
      .cell_wl       (cell_wl),
      .cell_blb      (cell_blb),
      .cell_wb       (cell_wb),
      .cell_write_en (cell_write_en),
      .cell_data_in  (cell_data_in),
      .cell_data_out (cell_data_out)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- cell array ----------------
   logic [NUM_CELLS-1:0] cells;

   always @(posedge clk) begin
      if (!cell_rst_n) begin
         cells <= '0;
      end else if (cell_write_en) begin
         for (int i = 0; i < NUM_CELLS; i++) begin
            if (cell_wb[i]) cells[i] <= cell_data_in;
         end
      end
   end

   always_comb begin
      cell_data_out = 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (!cell_blb && cell_wl[i]) cell_data_out = cells[i];
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: memory contents plus the response due for the request in flight.
   logic [NUM_CELLS-1:0] ref_mem;
   bit                   started, rst_edge, busy, rst_next, acc_next, hs_next;
   bit                   p_we, p_wd, m_we, m_wd, m_oob, m_rdata;
   int                   p_addr, m_addr, m_lat, t;
   bit                   e_ready, e_resp, e_en, e_blb, e_din;
   logic [NUM_CELLS-1:0] e_wl, e_wb;

   always begin
      @(negedge clk);
      // Apply what happened at the edge just passed.
      if (rst_next) begin
         started  = 1'b1;
         rst_edge = 1'b1;
         busy     = 1'b0;
         ref_mem  = '0;
      end else if (started) begin
         rst_edge = 1'b0;
         if (hs_next) busy = 1'b0;
         else if (busy) t++;
         if (acc_next) begin
            busy    = 1'b1;
            t       = 1;
            m_we    = p_we;
            m_wd    = p_wd;
            m_addr  = p_addr;
            m_oob   = (p_addr >= NUM_CELLS);
            m_rdata = 1'b0;
            if (!m_oob) begin
               if (m_we) ref_mem[m_addr] = m_wd;
               else m_rdata = ref_mem[m_addr];
            end
            m_lat = m_oob ? 1 : (m_we ? PRE + 1 : PRE + RD);
         end
      end

      e_ready = 1'b0; e_resp = 1'b0; e_en = 1'b0; e_blb = 1'b1; e_din = 1'b0;
      e_wl = '0; e_wb = '0;
      if (started) begin
         if (!busy) begin
            e_ready = !rst_edge;
         end else if (t > m_lat) begin
            e_resp = 1'b1;
         end else if (!m_oob && m_we && (t == PRE + 1)) begin
            e_wb[m_addr] = 1'b1;
            e_en         = 1'b1;
            e_din        = m_wd;
         end else if (!m_oob && !m_we && (t > PRE)) begin
            e_wl[m_addr] = 1'b1;
            e_blb        = 1'b0;
         end

         chk("req_ready", req_ready, e_ready);
         chk("rsp_valid", rsp_valid, e_resp);
         chk("cell_wl", cell_wl, e_wl);
         chk("cell_wb", cell_wb, e_wb);
         chk("cell_write_en", cell_write_en, e_en);
         chk("cell_blb", cell_blb, e_blb);
         chk("cell_data_in", cell_data_in, e_din);
         chk("cell_rst_n", cell_rst_n, !reset);
         chk("wl_onehot", ($countones(cell_wl) <= 1), 1);
         chk("wb_onehot", ($countones(cell_wb) <= 1), 1);
         chk("wl_wb_excl", ((cell_wl != '0) && (cell_wb != '0)), 0);
         if (rst_edge) begin
            chk("rst_rdata", rsp_rdata, 0);
            chk("rst_err", rsp_err, 0);
         end else if (e_resp) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", rsp_err, m_oob);
         end
      end

      // Note what the coming edge will do.
      rst_next = reset;
      acc_next = started && !reset && req_valid && e_ready;
      hs_next  = !reset && e_resp && rsp_ready;
      p_we     = req_we;
      p_wd     = req_wdata;
      p_addr   = int'(req_addr);
   end

   // ---------------- driver ----------------
   bit                   ok, valid_seen, got_rdata, got_err;
   int                   lat, acc_wait, en_cyc, wl_cyc;
   logic [NUM_CELLS-1:0] wl_seen, wb_seen;

   // Caller must be just after a posedge. Returns just after the response handshake edge.
   task automatic run(input logic we, input int a, input logic wd, input int bp, input bit hold);
      wl_seen = '0; wb_seen = '0; en_cyc = 0; wl_cyc = 0; lat = 0; acc_wait = 0;
      req_we = we; req_addr = AW'(a); req_wdata = wd; req_valid = 1'b1;
      rsp_ready = (bp == 0);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         acc_wait++;
         if (req_ready) ok = 1'b1;
      end
      chk("accept_seen", ok, 1);
      @(posedge clk);
      #1 req_valid = hold;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         wl_seen |= cell_wl;
         wb_seen |= cell_wb;
         en_cyc  += int'(cell_write_en);
         wl_cyc  += int'(cell_wl != '0);
         if (rsp_valid) ok = 1'b1;
         else lat++;
      end
      chk("rsp_seen", ok, 1);
      got_rdata = rsp_rdata;
      got_err   = rsp_err;
      if (bp > 0) begin
         repeat (bp - 1) @(negedge clk);
         @(posedge clk);
         #1 rsp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = 1'b0;
      rsp_ready = 1'b0;

      // Reset held for three edges.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cell_rst_n", cell_rst_n, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_blb", cell_blb, 1);
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1);
      @(posedge clk);
      #1;

      // Write then read cell 5.
      run(1'b1, 5, 1'b1, 0, 1'b0);
      chk("wr5_lat", lat, 2);
      chk("wr5_wb", wb_seen, 6'b10_0000);
      chk("wr5_en_cycles", en_cyc, 1);
      chk("wr5_wl", wl_seen, 0);
      chk("wr5_rdata", got_rdata, 0);
      run(1'b0, 5, 1'b0, 0, 1'b0);
      chk("rd5_lat", lat, 3);
      chk("rd5_wl", wl_seen, 6'b10_0000);
      chk("rd5_wl_cycles", wl_cyc, 2);
      chk("rd5_rdata", got_rdata, 1);

      // Back-pressure on a read of cell 3 (holds 0), next request waiting.
      run(1'b0, 3, 1'b0, 5, 1'b1);
      chk("bp_rdata", got_rdata, 0);
      run(1'b0, 3, 1'b0, 0, 1'b0);
      chk("bp_accept_wait", acc_wait, 1);

      // Out-of-range addresses.
      run(1'b0, 7, 1'b0, 0, 1'b0);
      chk("oob_lat", lat, 1);
      chk("oob_err", got_err, 1);
      chk("oob_rdata", got_rdata, 0);
      chk("oob_wl", wl_seen, 0);
      run(1'b1, 6, 1'b1, 0, 1'b0);
      chk("oob_wr_err", got_err, 1);
      chk("oob_wr_wb", wb_seen, 0);
      chk("oob_wr_en", en_cyc, 0);

      // Reset during the second read cycle.
      run(1'b1, 2, 1'b1, 0, 1'b0);
      req_we = 1'b0; req_addr = 3'd2; req_wdata = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1'b1;
      end
      chk("mid_accept", ok, 1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rd_wl", cell_wl, 6'b00_0100);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_wl", cell_wl, 0);
      chk("mid_blb", cell_blb, 1);
      valid_seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid) valid_seen = 1'b1;
      end
      chk("mid_no_rsp", valid_seen, 0);
      @(posedge clk);
      #1;
      run(1'b0, 2, 1'b0, 0, 1'b0);
      chk("mid_rd_after", got_rdata, 0);

      // Sweep every address with random write/read mix, then read everything back.
      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < 8; a++) begin
            run(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
         end
      end
      for (int a = 0; a < NUM_CELLS; a++) begin
         run(1'b0, a, 1'b0, 0, 1'b0);
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete, actual running required done");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
